uart_test: RTL and testbench

UART_TEST -- requirements
Module: uart_test

---
 rtl/uart_test_pkg.sv | 37 +++
 rtl/uart_tx_core.sv | 66 ++++++
 rtl/uart_test.sv | 171 +++++++++++++++++
 tb/tb_uart_test.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_test_pkg.sv
// Shared definitions for the UART greeting/echo block: bit-period derivation,
// greeting ROM and FSM state encodings.
package uart_test_pkg;

    typedef enum logic [1:0] {StIdle, StSend, StWait} ctrl_state_e;

    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWaitHigh} rx_state_e;

    localparam logic [3:0] GreetLast = 4'd12;
    // Index value meaning "all bytes handed over, waiting for the last frame to drain".
    localparam logic [3:0] GreetDone = 4'd13;

    function automatic int unsigned calc_cycle(input int unsigned clk_fre,
                                               input int unsigned baud_rate);
        return (clk_fre * 1_000_000) / baud_rate;
    endfunction

    // "HELLO ALINX\r\n"
    function automatic logic [7:0] greet_byte(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h48;
            4'd1:    return 8'h45;
            4'd2:    return 8'h4C;
            4'd3:    return 8'h4C;
            4'd4:    return 8'h4F;
            4'd5:    return 8'h20;
            4'd6:    return 8'h41;
            4'd7:    return 8'h4C;
            4'd8:    return 8'h49;
            4'd9:    return 8'h4E;
            4'd10:   return 8'h58;
            4'd11:   return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 serial transmitter: accepts a byte only while idle, drives each bit for CYCLE clocks.
module uart_tx_core
    import uart_test_pkg::*;
#(
    parameter int unsigned CYCLE = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_line
);

    localparam int unsigned CntW = (CYCLE > 2) ? $clog2(CYCLE) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CYCLE - 1);

    logic            busy_q, busy_d;
    logic [9:0]      frame_q, frame_d;
    logic [3:0]      bit_q, bit_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        busy_d  = busy_q;
        frame_d = frame_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        if (!busy_q) begin
            if (tx_valid) begin
                busy_d  = 1'b1;
                frame_d = {1'b1, tx_data, 1'b0};
                bit_d   = 4'd0;
                cnt_d   = '0;
            end
        end else if (cnt_q == CntMax) begin
            cnt_d   = '0;
            frame_d = {1'b1, frame_q[9:1]};
            if (bit_q == 4'd9) begin
                busy_d = 1'b0;
            end else begin
                bit_d = bit_q + 4'd1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            frame_q <= '1;
            bit_q   <= 4'd0;
            cnt_q   <= '0;
        end else begin
            busy_q  <= busy_d;
            frame_q <= frame_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
        end
    end

    // The idle cycle after each stop bit guarantees at least one high clock between frames.
    assign tx_ready = !busy_q;
    assign tx_line  = busy_q ? frame_q[0] : 1'b1;

endmodule

// File: rtl/uart_test.sv
// Periodic "HELLO ALINX\r\n" greeter with single-entry echo of received bytes.
module uart_test
    import uart_test_pkg::*;
#(
    parameter int unsigned CLK_FRE     = 50,
    parameter int unsigned BAUD_RATE   = 115200,
    parameter int unsigned WAIT_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic uart_rx,
    output logic uart_tx
);

    localparam int unsigned CYCLE = calc_cycle(CLK_FRE, BAUD_RATE);
    localparam int unsigned CntW  = (CYCLE > 2) ? $clog2(CYCLE) : 1;
    localparam logic [CntW-1:0] CntMax  = CntW'(CYCLE - 1);
    localparam logic [CntW-1:0] HalfMax = CntW'(CYCLE / 2 - 1);
    localparam logic [31:0]     WaitMax = 32'(WAIT_CYCLES - 1);

    logic            rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_e       rx_state_q, rx_state_d;
    logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_done;

    ctrl_state_e state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] wait_q, wait_d;
    logic        pend_valid_q, pend_valid_d;
    logic [7:0]  pend_data_q, pend_data_d;

    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done    = 1'b0;
        case (rx_state_q)
            RxIdle: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = RxStart;
                    rx_cnt_d   = '0;
                end
            end
            RxStart: begin
                if (rx_cnt_q == HalfMax) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_s2_q ? RxIdle : RxData;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxData: begin
                if (rx_cnt_q == CntMax) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = RxStop;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxStop: begin
                if (rx_cnt_q == CntMax) begin
                    rx_cnt_d = '0;
                    if (rx_s2_q) begin
                        rx_done    = 1'b1;
                        rx_state_d = RxIdle;
                    end else begin
                        rx_state_d = RxWaitHigh;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxWaitHigh: begin
                if (rx_s2_q) rx_state_d = RxIdle;
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        wait_d       = wait_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        tx_valid     = 1'b0;
        tx_data      = greet_byte(idx_q);
        case (state_q)
            StIdle: state_d = StSend;
            StSend: begin
                if (idx_q != GreetDone) begin
                    tx_valid = 1'b1;
                    if (tx_ready) idx_d = (idx_q == GreetLast) ? GreetDone : idx_q + 4'd1;
                end else if (tx_ready) begin
                    state_d = StWait;
                    idx_d   = 4'd0;
                    wait_d  = '0;
                end
            end
            StWait: begin
                // An echo frame still in flight simply delays the first greeting byte.
                if (wait_q == WaitMax) begin
                    state_d = StSend;
                end else begin
                    wait_d = wait_q + 32'd1;
                    if (pend_valid_q && tx_ready) begin
                        tx_valid     = 1'b1;
                        tx_data      = pend_data_q;
                        pend_valid_d = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (rx_done) begin
            pend_valid_d = 1'b1;
            pend_data_d  = rx_shift_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= RxIdle;
            rx_cnt_q     <= '0;
            rx_bit_q     <= 3'd0;
            rx_shift_q   <= 8'h00;
            state_q      <= StIdle;
            idx_q        <= 4'd0;
            wait_q       <= '0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= 8'h00;
        end else begin
            rx_s1_q      <= uart_rx;
            rx_s2_q      <= rx_s1_q;
            rx_prev_q    <= rx_s2_q;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            state_q      <= state_d;
            idx_q        <= idx_d;
            wait_q       <= wait_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
        end
    end

    uart_tx_core #(
        .CYCLE(CYCLE)
    ) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_line (uart_tx)
    );

endmodule

// File: tb/tb_uart_test.sv
// Bench for uart_test: decodes uart_tx into a frame queue and scores it against expected bytes.
`timescale 1ns/1ps
module tb_uart_test;

    localparam int unsigned CLK_FRE = 50;
    localparam int unsigned BAUD    = 1_000_000;
    localparam int unsigned WAITC   = 5000;
    localparam longint CLK_NS   = 20;
    localparam longint CYC      = (CLK_FRE * 1_000_000) / BAUD;
    localparam longint BIT_NS   = CYC * CLK_NS;
    localparam longint FRAME_NS = 10 * BIT_NS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic uart_rx = 1'b1;
    logic uart_tx;

    always #10 clk = ~clk;

    uart_test #(
        .CLK_FRE    (CLK_FRE),
        .BAUD_RATE  (BAUD),
        .WAIT_CYCLES(WAITC)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .uart_rx(uart_rx),
        .uart_tx(uart_tx)
    );

    typedef struct {
        logic [7:0] data;
        logic       stop;
        longint     t_start;
        longint     t_rise;
    } frame_t;

    frame_t     got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] greet[13] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h20, 8'h41,
                              8'h4C, 8'h49, 8'h4E, 8'h58, 8'h0D, 8'h0A};
    int     n_cmp = 0;
    int     n_err = 0;
    bit     dead = 1'b0;
    longint t_last_rise = 0;
    longint t_prev = 0;
    longint t_stop_rx = 0;
    longint t_rel = 0;

    always @(posedge uart_tx) t_last_rise = $time;

    initial begin : monitor
        frame_t f;
        forever begin
            @(negedge uart_tx);
            f.t_start = $time;
            f.t_rise  = 0;
            #(BIT_NS / 2);
            for (int i = 0; i < 8; i++) begin
                #(BIT_NS);
                f.data[i] = uart_tx;
                if (i == 0 && uart_tx === 1'b1) f.t_rise = t_last_rise;
            end
            #(BIT_NS);
            f.stop = uart_tx;
            got_q.push_back(f);
        end
    end

    task automatic pop_got(output frame_t f, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (!dead && got_q.size() == 0 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        if (got_q.size() != 0) begin
            f  = got_q.pop_front();
            ok = 1'b1;
        end else begin
            dead = 1'b1;
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            #(BIT_NS);
        end
        t_stop_rx = $time;
        uart_rx   = stop;
        #(BIT_NS);
        uart_rx = 1'b1;
    endtask

    task automatic test_reset;
        frame_t f;
        bit ok;
        logic [7:0] e;
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        #50;
        n_cmp++;
        if (uart_tx !== 1'b1) begin
            n_err++;
            $display("FAIL reset_tx_idle got %b want 1", uart_tx);
        end
        #50;
        n_cmp++;
        if (uart_tx !== 1'b1) begin
            n_err++;
            $display("FAIL reset_tx_end got %b want 1", uart_tx);
        end
        rst_n = 1'b1;
        t_rel = $time;
        exp_q.push_back(greet[0]);
        pop_got(f, ok);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || f.data !== e || f.stop !== 1'b1) begin
            n_err++;
            $display("FAIL first_byte got %h (ok=%0b) want %h", f.data, ok, e);
        end
        n_cmp++;
        if (!ok || f.t_start - t_rel > 2 * CLK_NS || f.t_start <= t_rel) begin
            n_err++;
            $display("FAIL first_start_latency got %0d ns want <= %0d ns", f.t_start - t_rel,
                     2 * CLK_NS);
        end
        t_prev = f.t_start;
    endtask

    // Consumes greeting bytes 1..12, checking content, spacing and bit width.
    task automatic test_greeting;
        frame_t f;
        bit ok;
        logic [7:0] e;
        longint d;
        for (int i = 1; i < 13; i++) exp_q.push_back(greet[i]);
        for (int i = 1; i < 13; i++) begin
            pop_got(f, ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || f.data !== e || f.stop !== 1'b1) begin
                n_err++;
                $display("FAIL greet_byte_%0d got %h stop %b (ok=%0b) want %h", i, f.data, f.stop,
                         ok, e);
            end
            d = f.t_start - t_prev;
            n_cmp++;
            if (!ok || d < FRAME_NS + CLK_NS || d > FRAME_NS + 5 * CLK_NS) begin
                n_err++;
                $display("FAIL greet_spacing_%0d got %0d ns want %0d..%0d ns", i, d,
                         FRAME_NS + CLK_NS, FRAME_NS + 5 * CLK_NS);
            end
            if (ok && e[0]) begin
                d = f.t_rise - f.t_start;
                n_cmp++;
                if (d < BIT_NS - 20 || d > BIT_NS + 20) begin
                    n_err++;
                    $display("FAIL bit_period_%0d got %0d ns want %0d ns", i, d, BIT_NS);
                end
            end
            t_prev = f.t_start;
        end
    endtask

    task automatic test_echo_wait;
        frame_t f;
        bit ok;
        logic [7:0] e;
        #(2 * BIT_NS);
        @(negedge clk);
        exp_q.push_back(8'h41);
        send_rx(8'h41, 1'b1);
        pop_got(f, ok);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || f.data !== e) begin
            n_err++;
            $display("FAIL echo_wait_data got %h (ok=%0b) want %h", f.data, ok, e);
        end
        n_cmp++;
        if (!ok || f.t_start < t_stop_rx || f.t_start - t_stop_rx > 2 * BIT_NS) begin
            n_err++;
            $display("FAIL echo_wait_latency got %0d ns want <= %0d ns", f.t_start - t_stop_rx,
                     2 * BIT_NS);
        end
    endtask

    task automatic test_wait_gap;
        frame_t f;
        bit ok;
        logic [7:0] e;
        longint gap;
        exp_q.push_back(greet[0]);
        pop_got(f, ok);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || f.data !== e) begin
            n_err++;
            $display("FAIL second_greet_first got %h (ok=%0b) want %h", f.data, ok, e);
        end
        gap = (f.t_start - (t_prev + FRAME_NS)) / CLK_NS;
        n_cmp++;
        if (!ok || gap < WAITC || gap > WAITC + 8) begin
            n_err++;
            $display("FAIL wait_gap got %0d clocks want %0d..%0d", gap, WAITC, WAITC + 8);
        end
        t_prev = f.t_start;
    endtask

    task automatic test_echo_during_send;
        frame_t f;
        bit ok;
        logic [7:0] e;
        longint t_end;
        @(negedge clk);
        send_rx(8'h5A, 1'b1);
        test_greeting();
        t_end = t_prev + FRAME_NS;
        exp_q.push_back(8'h5A);
        pop_got(f, ok);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || f.data !== e) begin
            n_err++;
            $display("FAIL echo_after_send_data got %h (ok=%0b) want %h", f.data, ok, e);
        end
        n_cmp++;
        if (!ok || f.t_start < t_end) begin
            n_err++;
            $display("FAIL echo_after_send_order got start %0d ns want >= %0d ns", f.t_start,
                     t_end);
        end
    endtask

    task automatic test_rx_errors;
        frame_t f;
        bit ok;
        logic [7:0] e;
        #(BIT_NS);
        @(negedge clk);
        uart_rx = 1'b0;
        #(BIT_NS / 2);
        uart_rx = 1'b1;
        #(2 * BIT_NS);
        send_rx(8'h77, 1'b0);
        #(3 * BIT_NS);
        exp_q.push_back(8'h33);
        send_rx(8'h33, 1'b1);
        pop_got(f, ok);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || f.data !== e) begin
            n_err++;
            $display("FAIL rx_error_then_valid got %h (ok=%0b) want %h", f.data, ok, e);
        end
    endtask

    task automatic test_last_byte_wins;
        frame_t f;
        bit ok;
        logic [7:0] e;
        exp_q.push_back(greet[0]);
        pop_got(f, ok);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || f.data !== e) begin
            n_err++;
            $display("FAIL third_greet_first got %h (ok=%0b) want %h", f.data, ok, e);
        end
        t_prev = f.t_start;
        @(negedge clk);
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        test_greeting();
        exp_q.push_back(8'h22);
        pop_got(f, ok);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || f.data !== e) begin
            n_err++;
            $display("FAIL last_byte_wins got %h (ok=%0b) want %h", f.data, ok, e);
        end
    endtask

    task automatic test_reset_mid;
        frame_t f;
        bit ok;
        logic [7:0] e;
        int n;
        for (int i = 0; i < 2; i++) exp_q.push_back(greet[i]);
        for (int i = 0; i < 2; i++) begin
            pop_got(f, ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || f.data !== e) begin
                n_err++;
                $display("FAIL pre_reset_byte_%0d got %h (ok=%0b) want %h", i, f.data, ok, e);
            end
        end
        n = 0;
        while (uart_tx !== 1'b0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        #(BIT_NS / 4);
        n_cmp++;
        if (uart_tx !== 1'b0) begin
            n_err++;
            $display("FAIL mid_frame_low got %b want 0", uart_tx);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (uart_tx !== 1'b1) begin
            n_err++;
            $display("FAIL async_reset_tx got %b want 1", uart_tx);
        end
        #(12 * BIT_NS);
        n_cmp++;
        if (uart_tx !== 1'b1) begin
            n_err++;
            $display("FAIL reset_hold_tx got %b want 1", uart_tx);
        end
        got_q.delete();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        t_rel = $time;
        for (int i = 0; i < 3; i++) exp_q.push_back(greet[i]);
        for (int i = 0; i < 3; i++) begin
            pop_got(f, ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || f.data !== e) begin
                n_err++;
                $display("FAIL restart_byte_%0d got %h (ok=%0b) want %h", i, f.data, ok, e);
            end
            if (i == 0) begin
                n_cmp++;
                if (!ok || f.t_start <= t_rel || f.t_start - t_rel > 2 * CLK_NS) begin
                    n_err++;
                    $display("FAIL restart_latency got %0d ns want <= %0d ns", f.t_start - t_rel,
                             2 * CLK_NS);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_greeting();
        test_echo_wait();
        test_wait_gap();
        test_echo_during_send();
        test_rx_errors();
        test_last_byte_wins();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
